fpu_dispatch: RTL

Parametrised command-queue front-end for the FPU datapath. It buffers operation commands in a FIFO and issues them one at a time to the unit array (fclass … sqrt). It waits on multi-cycle div/sqrt with a watchdog, queues results with exception flags and a unit tag, accumulates sticky RISC-V fflags, and raises a maskable interrupt. It sits between the Wishbone/LA register layer and the FPU unit instances, replacing direct single-shot valid_in driving.

---
 rtl/fpu_dispatch_pkg.sv | 60 ++++++
 rtl/fpu_dispatch_if.sv | 31 +++
 rtl/fpu_sync_fifo.sv | 53 +++++
 rtl/fpu_dispatch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fpu_dispatch_pkg.sv
// rtl/fpu_dispatch_pkg.sv - shared types and constants for the FPU command dispatcher
package fpu_dispatch_pkg;

    localparam int FPU_XLEN  = 32;
    localparam int NUM_UNITS = 11;

    localparam logic [3:0] UNIT_FCLASS   = 4'd0;
    localparam logic [3:0] UNIT_SIGN_INJ = 4'd1;
    localparam logic [3:0] UNIT_COMPARE  = 4'd2;
    localparam logic [3:0] UNIT_MIN_MAX  = 4'd3;
    localparam logic [3:0] UNIT_I2F      = 4'd4;
    localparam logic [3:0] UNIT_F2I      = 4'd5;
    localparam logic [3:0] UNIT_ADD_SUB  = 4'd6;
    localparam logic [3:0] UNIT_MUL      = 4'd7;
    localparam logic [3:0] UNIT_FMA      = 4'd8;
    localparam logic [3:0] UNIT_DIV      = 4'd9;
    localparam logic [3:0] UNIT_SQRT     = 4'd10;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_MC
    } state_e;

    typedef struct packed {
        logic [3:0]          unit;
        logic [1:0]          op;
        logic [2:0]          frm;
        logic [FPU_XLEN-1:0] a;
        logic [FPU_XLEN-1:0] b;
        logic [FPU_XLEN-1:0] c;
    } cmd_t;

    typedef struct packed {
        logic [FPU_XLEN-1:0] data;
        logic [4:0]          exc;
        logic [3:0]          unit;
        logic                illegal;
        logic                timeout;
    } res_t;

    // sign_inj and compare have no fourth sub-operation
    function automatic logic is_illegal(input logic [3:0] unit, input logic [1:0] op);
        logic ill;
        case (unit)
            UNIT_FCLASS, UNIT_MIN_MAX, UNIT_I2F, UNIT_F2I, UNIT_ADD_SUB,
            UNIT_MUL, UNIT_FMA, UNIT_DIV, UNIT_SQRT: ill = 1'b0;
            UNIT_SIGN_INJ, UNIT_COMPARE:             ill = (op == 2'b11);
            default:                                 ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/fpu_dispatch_if.sv
// rtl/fpu_dispatch_if.sv - command and result handshake bundle of the FPU dispatcher
interface fpu_dispatch_if #(
    parameter int XLEN = 32
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_unit;
    logic [1:0]      cmd_op;
    logic [2:0]      cmd_frm;
    logic [XLEN-1:0] cmd_a;
    logic [XLEN-1:0] cmd_b;
    logic [XLEN-1:0] cmd_c;

    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic [4:0]      res_exc;
    logic [3:0]      res_unit;
    logic            res_illegal;
    logic            res_timeout;

    modport master (
        output cmd_valid, cmd_unit, cmd_op, cmd_frm, cmd_a, cmd_b, cmd_c, res_ready,
        input  cmd_ready, res_valid, res_data, res_exc, res_unit, res_illegal, res_timeout
    );

    modport slave (
        input  cmd_valid, cmd_unit, cmd_op, cmd_frm, cmd_a, cmd_b, cmd_c, res_ready,
        output cmd_ready, res_valid, res_data, res_exc, res_unit, res_illegal, res_timeout
    );
endinterface

// File: rtl/fpu_sync_fifo.sv
// rtl/fpu_sync_fifo.sv - single-clock FIFO with occupancy count, power-of-2 depth
module fpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/fpu_dispatch.sv
// rtl/fpu_dispatch.sv - queued command issue to the FPU unit array with result queue,
// div/sqrt watchdog, sticky fflags and maskable interrupt
module fpu_dispatch
    import fpu_dispatch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_l,
    fpu_dispatch_if.slave        bus,
    output logic [NUM_UNITS-1:0] iss_valid_in,
    output logic [1:0]           iss_op,
    output logic [2:0]           iss_frm,
    output logic [XLEN-1:0]      iss_a,
    output logic [XLEN-1:0]      iss_b,
    output logic [XLEN-1:0]      iss_c,
    input  logic [XLEN-1:0]      dp_result,
    input  logic [4:0]           dp_exceptions,
    input  logic                 dp_mc_valid,
    output logic [4:0]           fflags,
    input  logic                 fflags_clr,
    input  logic [4:0]           irq_mask,
    output logic                 irq,
    output logic [7:0]           illegal_cnt,
    output logic                 timeout_err,
    output logic                 busy
);
    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int RW = $clog2(RES_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    cmd_t          iss_q, iss_d;
    logic          iss_ill_q, iss_ill_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [4:0]    fflags_q, fflags_d;
    logic [7:0]    ill_cnt_q, ill_cnt_d;
    logic          tmo_err_q, tmo_err_d;

    cmd_t          cmd_in, cmd_head;
    res_t          res_in, res_head;
    logic          cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic          res_push, res_pop, res_full, res_empty;
    logic [CW-1:0] cmd_count;
    logic [RW-1:0] res_count;

    logic          iss_mc, mc_pulse, in_wait, timed_out, mc_done, issue;
    int            res_next;

    fpu_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_l),
        .push      (cmd_push),
        .push_data (cmd_in),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .count     (cmd_count)
    );

    fpu_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_l),
        .push      (res_push),
        .push_data (res_in),
        .pop       (res_pop),
        .pop_data  (res_head),
        .full      (res_full),
        .empty     (res_empty),
        .count     (res_count)
    );

    always_comb begin
        cmd_in.unit = bus.cmd_unit;
        cmd_in.op   = bus.cmd_op;
        cmd_in.frm  = bus.cmd_frm;
        cmd_in.a    = bus.cmd_a;
        cmd_in.b    = bus.cmd_b;
        cmd_in.c    = bus.cmd_c;
        cmd_push    = bus.cmd_valid && !cmd_full;

        iss_mc    = !iss_ill_q && (iss_q.unit == UNIT_DIV || iss_q.unit == UNIT_SQRT);
        mc_pulse  = (state_q == ST_ISSUE) && iss_mc;
        in_wait   = (state_q == ST_WAIT_MC);
        timed_out = in_wait && !dp_mc_valid && (wd_q == TW'(TIMEOUT));
        mc_done   = in_wait && (dp_mc_valid || timed_out);

        res_push       = ((state_q == ST_ISSUE) && !iss_mc) || mc_done;
        res_in.data    = dp_result;
        res_in.exc     = dp_exceptions;
        res_in.unit    = iss_q.unit;
        res_in.illegal = 1'b0;
        res_in.timeout = 1'b0;
        if ((state_q == ST_ISSUE) && iss_ill_q) begin
            res_in.data    = '0;
            res_in.exc     = '0;
            res_in.illegal = 1'b1;
        end
        if (timed_out) begin
            res_in.data         = '0;
            res_in.exc          = '0;
            res_in.exc[FLAG_NV] = 1'b1;
            res_in.timeout      = 1'b1;
        end
        res_pop = bus.res_ready && !res_empty;

        // The result of a command issued now is pushed next cycle, so room is
        // judged against the occupancy after this cycle's push and pop.
        res_next = int'(res_count) + int'(res_push) - int'(res_pop);
        issue    = !cmd_empty && !res_full && (res_next < RES_DEPTH)
                   && !mc_pulse && (!in_wait || mc_done);
        cmd_pop  = issue;

        iss_d     = issue ? cmd_head : iss_q;
        iss_ill_d = issue ? is_illegal(cmd_head.unit, cmd_head.op) : iss_ill_q;

        state_d = ST_IDLE;
        if (issue)                   state_d = ST_ISSUE;
        else if (mc_pulse)           state_d = ST_WAIT_MC;
        else if (in_wait && !mc_done) state_d = ST_WAIT_MC;

        wd_d = '0;
        if (mc_pulse)                 wd_d = TW'(1);
        else if (in_wait && !mc_done) wd_d = wd_q + TW'(1);

        fflags_d  = (fflags_clr ? 5'b0 : fflags_q) | (res_push ? res_in.exc : 5'b0);
        tmo_err_d = (fflags_clr ? 1'b0 : tmo_err_q) | timed_out;
        ill_cnt_d = ill_cnt_q;
        if (res_push && res_in.illegal && ill_cnt_q != 8'hFF) ill_cnt_d = ill_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= ST_IDLE;
            iss_q     <= '0;
            iss_ill_q <= 1'b0;
            wd_q      <= '0;
            fflags_q  <= '0;
            ill_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iss_q     <= iss_d;
            iss_ill_q <= iss_ill_d;
            wd_q      <= wd_d;
            fflags_q  <= fflags_d;
            ill_cnt_q <= ill_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign iss_valid_in = ((state_q == ST_ISSUE) && !iss_ill_q)
                          ? (NUM_UNITS'(1) << iss_q.unit) : '0;
    assign iss_op   = iss_q.op;
    assign iss_frm  = iss_q.frm;
    assign iss_a    = iss_q.a;
    assign iss_b    = iss_q.b;
    assign iss_c    = iss_q.c;

    assign bus.cmd_ready   = (cmd_count < CW'(CMD_DEPTH));
    assign bus.res_valid   = !res_empty;
    assign bus.res_data    = res_head.data;
    assign bus.res_exc     = res_head.exc;
    assign bus.res_unit    = res_head.unit;
    assign bus.res_illegal = res_head.illegal;
    assign bus.res_timeout = res_head.timeout;

    assign fflags      = fflags_q;
    assign timeout_err = tmo_err_q;
    assign illegal_cnt = ill_cnt_q;
    assign irq         = (|(fflags_q & irq_mask)) | tmo_err_q;
    assign busy        = (state_q != ST_IDLE) || !cmd_empty || !res_empty;

endmodule
